mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and drives the data-memory bus with a valid/ready request channel and a response channel. It also aligns store data and byte strobes, and extracts and sign- or zero-extends load data into the MEM/WB `mem_data_in` input. While an access is outstanding it stalls the pipeline, and it flags misaligned or illegal accesses for the trap path.

---
 rtl/riscv_lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/mem_stage_lsu.sv | 133 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type and the funct3 legality check.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/replication and load extract/extend.
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_lane_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wstrb     = 4'b1111;
        st_lane_data = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_wstrb     = 4'b0001 << st_off;
                st_lane_data = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb     = 4'b0011 << {st_off[1], 1'b0};
                st_lane_data = {2{st_wdata[15:0]}};
            end
            default: begin
                st_wstrb     = 4'b1111;
                st_lane_data = st_wdata;
            end
        endcase
    end

    // Shifting the word down selects the addressed byte/halfword lane.
    assign byte_shift = ld_rdata >> {ld_off, 3'b000};
    assign half_shift = ld_rdata >> {ld_off[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-bus requests, stalls the pipeline
// while an access is outstanding and flags misaligned/illegal accesses.
module mem_stage_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_data_out,
    output logic        stall,
    output logic        lsu_trap
);

    lsu_state_t  state_reg;
    logic [29:0] waddr_reg;
    logic [1:0]  off_reg;
    logic [2:0]  f3_reg;
    logic        we_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;
    logic [31:0] mem_data_reg;

    logic        mem_op;
    logic        misaligned;
    logic        bad_access;
    logic        issue;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [3:0]  issue_wstrb;
    logic [31:0] issue_wdata;
    logic [31:0] ld_data;

    assign mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
    assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                        ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
    assign bad_access = ~f3_legal(ex_mem_write, ex_funct3) | misaligned;

    // Gated by reset so nothing leaks onto the bus while reset is held.
    assign issue    = reset & (state_reg == ST_IDLE) & mem_op & ~bad_access;
    assign lsu_trap = reset & (state_reg == ST_IDLE) & mem_op & bad_access;

    lsu_align u_align (
        .st_funct3    (ex_funct3),
        .st_off       (ex_addr[1:0]),
        .st_wdata     (ex_wdata),
        .st_wstrb     (al_wstrb),
        .st_lane_data (al_wdata),
        .ld_funct3    (f3_reg),
        .ld_off       (off_reg),
        .ld_rdata     (dbus_rdata),
        .ld_data      (ld_data)
    );

    assign issue_wstrb = ex_mem_write ? al_wstrb : 4'b0000;
    assign issue_wdata = ex_mem_write ? al_wdata : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            waddr_reg    <= '0;
            off_reg      <= '0;
            f3_reg       <= '0;
            we_reg       <= 1'b0;
            wstrb_reg    <= '0;
            wdata_reg    <= '0;
            mem_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        waddr_reg <= ex_addr[31:2];
                        off_reg   <= ex_addr[1:0];
                        f3_reg    <= ex_funct3;
                        we_reg    <= ex_mem_write;
                        wstrb_reg <= issue_wstrb;
                        wdata_reg <= issue_wdata;
                        state_reg <= dbus_req_ready ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dbus_req_ready) state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dbus_rsp_valid) begin
                        mem_data_reg <= we_reg ? 32'h0 : ld_data;
                        state_reg    <= ST_DONE;
                    end
                end
                // EX/MEM still shows the finished instruction here, so ignore it.
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dbus_req_valid = 1'b0;
        dbus_addr      = 32'h0;
        dbus_we        = 1'b0;
        dbus_wstrb     = 4'b0000;
        dbus_wdata     = 32'h0;
        if (issue) begin
            dbus_req_valid = 1'b1;
            dbus_addr      = {ex_addr[31:2], 2'b00};
            dbus_we        = ex_mem_write;
            dbus_wstrb     = issue_wstrb;
            dbus_wdata     = issue_wdata;
        end else if (state_reg == ST_REQ) begin
            dbus_req_valid = 1'b1;
            dbus_addr      = {waddr_reg, 2'b00};
            dbus_we        = we_reg;
            dbus_wstrb     = wstrb_reg;
            dbus_wdata     = wdata_reg;
        end
    end

    assign stall        = issue | (state_reg == ST_REQ) | (state_reg == ST_WAIT);
    assign mem_data_out = mem_data_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a queue of expected load results.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        dbus_req_valid, dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;
    logic [31:0] mem_data_out;
    logic        stall, lsu_trap;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    mem_stage_lsu dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_addr      (dbus_addr),
        .dbus_we        (dbus_we),
        .dbus_wstrb     (dbus_wstrb),
        .dbus_wdata     (dbus_wdata),
        .dbus_rsp_valid (dbus_rsp_valid),
        .dbus_rdata     (dbus_rdata),
        .mem_data_out   (mem_data_out),
        .stall          (stall),
        .lsu_trap       (lsu_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One memory access with rdly cycles of ready=0 and the response
    // arriving ddly cycles later than zero-wait.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int rdly, input int ddly,
                             input logic [3:0] e_strb, input logic [31:0] e_wdata,
                             input logic [31:0] e_data);
        int stall_cnt;
        logic [31:0] got;
        stall_cnt      = 0;
        ex_valid       = 1'b1;
        ex_mem_read    = rd;
        ex_mem_write   = wr;
        ex_funct3      = f3;
        ex_addr        = addr;
        ex_wdata       = wd;
        dbus_rdata     = rdata;
        dbus_rsp_valid = 1'b0;
        dbus_req_ready = (rdly == 0);
        exp_q.push_back(e_data);
        for (int c = 0; c <= rdly; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (c == 0 || c == rdly) begin
                check({tag, " req_valid"}, {31'h0, dbus_req_valid}, 32'h1);
                check({tag, " addr"}, dbus_addr, {addr[31:2], 2'b00});
                check({tag, " we"}, {31'h0, dbus_we}, {31'h0, wr});
                check({tag, " wstrb"}, {28'h0, dbus_wstrb}, {28'h0, e_strb});
                check({tag, " wdata"}, dbus_wdata, e_wdata);
            end
            @(posedge clk); #1;
            if (c + 1 == rdly) dbus_req_ready = 1'b1;
        end
        dbus_req_ready = 1'b0;
        for (int d = 0; d <= ddly; d++) begin
            dbus_rsp_valid = (d == ddly);
            @(negedge clk);
            if (stall) stall_cnt++;
            @(posedge clk); #1;
        end
        dbus_rsp_valid = 1'b0;
        @(negedge clk);
        got = exp_q.pop_front();
        check({tag, " done stall"}, {31'h0, stall}, 32'h0);
        check({tag, " done req_valid"}, {31'h0, dbus_req_valid}, 32'h0);
        check({tag, " mem_data_out"}, mem_data_out, got);
        check({tag, " stall cycles"}, stall_cnt, 2 + rdly + ddly);
        $display("txn %s addr=%h f3=%0d data=%h stall_cycles=%0d", tag, addr, f3, mem_data_out, stall_cnt);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic trap_case(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = addr;
        @(negedge clk);
        check({tag, " lsu_trap"}, {31'h0, lsu_trap}, 32'h1);
        check({tag, " req_valid"}, {31'h0, dbus_req_valid}, 32'h0);
        check({tag, " stall"}, {31'h0, stall}, 32'h0);
        $display("txn %s trap=%0b stall=%0b", tag, lsu_trap, stall);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_funct3 = 0; ex_addr = 0; ex_wdata = 0;
        dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_valid", {31'h0, dbus_req_valid}, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset mem_data_out", mem_data_out, 32'h0);
        check("reset trap", {31'h0, lsu_trap}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        do_access("LW", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'hDEADBEEF);
        do_access("LB", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80);
        do_access("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 4'h0, 32'h0, 32'h00000080);
        do_access("LH", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 4'h0, 32'h0, 32'hFFFF80FF);
        do_access("LHU", 1, 0, 3'b101, 32'h100, 32'h0, 32'h80FF9234, 0, 0, 4'h0, 32'h0, 32'h00009234);
        do_access("SB", 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        do_access("SH", 0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0, 0, 4'b1100, 32'h12341234, 32'h0);
        do_access("SW", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        do_access("LW bp", 1, 0, 3'b010, 32'h10C, 32'h0, 32'h0BADF00D, 3, 1, 4'h0, 32'h0, 32'h0BADF00D);

        trap_case("LW mis", 1, 0, 3'b010, 32'h102);
        trap_case("SH mis", 0, 1, 3'b001, 32'h201);
        trap_case("LD f3=011", 1, 0, 3'b011, 32'h100);
        trap_case("SB f3=100", 0, 1, 3'b100, 32'h100);

        // Non-memory instruction: no stall, no trap, no request.
        ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 3'b011;
        @(negedge clk);
        check("alu stall", {31'h0, stall}, 32'h0);
        check("alu req_valid", {31'h0, dbus_req_valid}, 32'h0);
        check("alu trap", {31'h0, lsu_trap}, 32'h0);
        @(posedge clk); #1;
        ex_valid = 0;

        // Reset while waiting for a response, then a stray response.
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_addr = 32'h300; dbus_req_ready = 1; dbus_rdata = 32'h12345678;
        @(posedge clk); #1;
        dbus_req_ready = 0;
        @(negedge clk);
        check("rst-wait stall before", {31'h0, stall}, 32'h1);
        reset = 1'b0;
        #1;
        check("rst-wait req_valid", {31'h0, dbus_req_valid}, 32'h0);
        check("rst-wait stall", {31'h0, stall}, 32'h0);
        check("rst-wait mem_data_out", mem_data_out, 32'h0);
        check("rst-wait addr", dbus_addr, 32'h0);
        @(posedge clk); #1;
        ex_valid = 0;
        reset = 1'b1;
        dbus_rsp_valid = 1'b1;
        @(negedge clk);
        check("stray stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0;
        @(negedge clk);
        check("stray mem_data_out", mem_data_out, 32'h0);
        $display("txn reset-in-wait stray response ignored mem_data_out=%h", mem_data_out);
        @(posedge clk); #1;

        do_access("LW post-rst", 1, 0, 3'b010, 32'h304, 32'h0, 32'h55AA33CC, 0, 0, 4'h0, 32'h0, 32'h55AA33CC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
